// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter: one requester per message,
// grant held until its last byte is serialized or the owner stalls past TIMEOUT.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               active
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  owner;
    logic           last_q;
    logic [CW-1:0]  idle_cnt;
    logic [CW-1:0]  idle_cnt_inc;

    logic           found;
    logic [PW-1:0]  win_idx;
    logic [PW-1:0]  cand;
    logic           owner_valid;
    logic           accept;

    // Walk the requesters starting just after the previous owner; the wrap is
    // explicit so non-power-of-two N_REQ never indexes a phantom requester.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == PW'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == LOAD && !tx_busy) begin
            req_ready = grant;
        end
    end

    assign owner_valid  = req_valid[owner];
    assign accept       = (state == LOAD) && !tx_busy && owner_valid;
    assign idle_cnt_inc = (idle_cnt == CW'(TIMEOUT)) ? idle_cnt : idle_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= PW'(N_REQ - 1);
            owner    <= '0;
            grant    <= '0;
            active   <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            last_q   <= 1'b0;
            idle_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner    <= win_idx;
                        grant    <= GRANT_ONE << win_idx;
                        active   <= 1'b1;
                        idle_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        tx_data  <= req_data[{owner, 3'b000} +: 8];
                        last_q   <= req_last[owner];
                        idle_cnt <= '0;
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end else if (!owner_valid) begin
                        idle_cnt <= idle_cnt_inc;
                        // A stalled owner forfeits the rest of its message.
                        if (idle_cnt_inc == CW'(TIMEOUT)) begin
                            ptr    <= owner;
                            grant  <= '0;
                            active <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            ptr    <= owner;
                            grant  <= '0;
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idle_cnt <= '0;
                            state    <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester message queues, a simple
// serializer, and an event-timed protocol scoreboard with round-robin ordering.
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic [N_REQ-1:0]   grant;
    logic               active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .active    (active)
    );

    // Each entry is {last, byte}; a requester offers its queue head whenever non-empty.
    logic [8:0] msg_q [N_REQ][$];

    int         checks;
    int         passes;
    int         cyc;
    int         owner;
    int         last_owner;
    int         release_due;
    int         idle_cnt;
    int         busy_cnt;
    int         hold_cnt;
    int         busy_fixed;
    int         stall_pct;
    int         pulses;
    int         stall_run [N_REQ];
    bit         in_load;
    bit         waiting;
    bit         pend_last;
    bit         pulse_last;
    bit         prev_rst;
    bit         prev_hs;
    bit         rst_req;
    logic [8:0] prev_word;
    logic [N_REQ-1:0] prev_valid;
    logic [7:0] exp_data;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int idx);
        logic [N_REQ-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic int rrPick(input int from, input logic [N_REQ-1:0] v);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(from + k) % N_REQ]) return (from + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int pendingWork();
        int n;
        n = 0;
        for (int i = 0; i < N_REQ; i++) n += msg_q[i].size();
        if (owner >= 0) n++;
        if (busy_cnt > 0 || hold_cnt > 0) n++;
        return n;
    endfunction

    task automatic modelReset();
        owner       = -1;
        last_owner  = N_REQ - 1;
        release_due = -1;
        idle_cnt    = 0;
        in_load     = 1'b0;
        waiting     = 1'b0;
        pend_last   = 1'b0;
        pulse_last  = 1'b0;
        exp_data    = 8'h00;
    endtask

    task automatic pushMsg(input int req, input int len);
        for (int b = 0; b < len; b++) begin
            msg_q[req].push_back({(b == len - 1), 8'($urandom)});
        end
    endtask

    // One clock: check what the last edge produced, drive this cycle, then
    // record what the coming edge should do.
    task automatic runCycle();
        bit         exp_start;
        bit         hs;
        bit         nl;
        bit         stall;
        logic [8:0] word;
        logic [N_REQ-1:0] exp_ready;

        @(posedge clk);
        #1;
        cyc++;
        exp_start = 1'b0;
        if (prev_rst) begin
            modelReset();
        end else begin
            exp_start = prev_hs;
            if (prev_hs) exp_data = prev_word[7:0];
            if (owner < 0) begin
                if (prev_valid != '0) begin
                    owner    = rrPick(last_owner, prev_valid);
                    in_load  = 1'b1;
                    idle_cnt = 0;
                end
            end else if (cyc == release_due) begin
                last_owner  = owner;
                owner       = -1;
                release_due = -1;
                in_load     = 1'b0;
                waiting     = 1'b0;
            end
        end
        if (exp_start) pulses++;

        checkOutput("grant", grant, onehot(owner));
        checkOutput("active", active, owner >= 0);
        checkOutput("tx_start", tx_start, exp_start);
        checkOutput("tx_data", tx_data, exp_data);

        if (tx_start) busy_cnt = (busy_fixed > 0) ? busy_fixed : $urandom_range(12, 2);
        tx_busy = (busy_cnt > 0) || (hold_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (hold_cnt > 0) hold_cnt--;

        rst     = rst_req;
        rst_req = 1'b0;

        for (int i = 0; i < N_REQ; i++) begin
            if (msg_q[i].size() > 0) begin
                stall = (owner == i) && (stall_run[i] < 3) && ($urandom_range(99, 0) < stall_pct);
                req_valid[i] = !stall;
                stall_run[i] = stall ? stall_run[i] + 1 : 0;
                req_data[8*i +: 8] = msg_q[i][0][7:0];
                req_last[i] = msg_q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                stall_run[i] = 0;
            end
        end

        #1;
        exp_ready = (in_load && !tx_busy) ? onehot(owner) : '0;
        checkOutput("req_ready", req_ready, exp_ready);

        hs   = 1'b0;
        word = '0;
        nl   = in_load;
        if (in_load) begin
            if (!tx_busy && req_valid[owner]) begin
                hs        = 1'b1;
                word      = msg_q[owner].pop_front();
                pend_last = word[8];
                nl        = 1'b0;
            end else if (!req_valid[owner]) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) begin
                    release_due = cyc + 1;
                    nl          = 1'b0;
                end
            end
        end
        if (waiting && !tx_busy) begin
            waiting = 1'b0;
            if (pulse_last) begin
                release_due = cyc + 1;
            end else begin
                nl       = 1'b1;
                idle_cnt = 0;
            end
        end
        if (exp_start) begin
            waiting    = 1'b1;
            pulse_last = pend_last;
        end
        in_load    = nl;
        prev_hs    = hs;
        prev_word  = word;
        prev_valid = req_valid;
        prev_rst   = rst;
    endtask

    task automatic applyStimulus(input int budget);
        int n;
        n = 0;
        while (pendingWork() > 0 && n < budget) begin
            runCycle();
            n++;
        end
        if (pendingWork() > 0) checkOutput("drain_budget", pendingWork(), 0);
        runCycle();
        runCycle();
    endtask

    task automatic resetDut();
        rst_req = 1'b1;
        runCycle();
    endtask

    initial begin
        int n;
        checks = 0; passes = 0; cyc = 0; pulses = 0;
        busy_cnt = 0; hold_cnt = 0; busy_fixed = 10; stall_pct = 0;
        for (int i = 0; i < N_REQ; i++) stall_run[i] = 0;
        rst = 1'b1; rst_req = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; tx_busy = 1'b0;
        prev_rst = 1'b1; prev_hs = 1'b0; prev_word = '0; prev_valid = '0;
        modelReset();

        runCycle();
        $display("[TB] requester 1 sends 41 42 43");
        msg_q[1].push_back({1'b0, 8'h41});
        msg_q[1].push_back({1'b0, 8'h42});
        msg_q[1].push_back({1'b1, 8'h43});
        applyStimulus(500);

        $display("[TB] requesters 0 and 2 contend at reset release");
        pushMsg(0, 2);
        pushMsg(2, 2);
        resetDut();
        applyStimulus(500);

        $display("[TB] fairness with four always-valid requesters");
        busy_fixed = 3;
        resetDut();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_REQ; i++) pushMsg(i, 1);
        end
        applyStimulus(1000);

        $display("[TB] stalled owner times out");
        resetDut();
        msg_q[3].push_back({1'b0, 8'h77});
        n = 0;
        while (owner != 3 && n < 20) begin
            runCycle();
            n++;
        end
        checkOutput("stall_owner", onehot(owner), onehot(3));
        msg_q[1].push_back({1'b1, 8'h55});
        applyStimulus(500);

        $display("[TB] backpressure at LOAD entry");
        resetDut();
        hold_cnt = 7;
        msg_q[0].push_back({1'b1, 8'h99});
        applyStimulus(500);

        $display("[TB] reset during WAIT of second byte");
        busy_fixed = 6;
        resetDut();
        pulses = 0;
        pushMsg(2, 3);
        n = 0;
        while (!(pulses == 2 && waiting) && n < 200) begin
            runCycle();
            n++;
        end
        checkOutput("mid_msg_pulses", pulses, 2);
        pushMsg(3, 1);
        pushMsg(0, 1);
        rst_req = 1'b1;
        runCycle();
        runCycle();
        msg_q[2].delete();
        applyStimulus(500);

        $display("[TB] randomized traffic");
        busy_fixed = 0;
        stall_pct  = 25;
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < N_REQ; i++) begin
                int nmsg;
                nmsg = $urandom_range(3, 0);
                for (int m = 0; m < nmsg; m++) pushMsg(i, $urandom_range(4, 1));
            end
            applyStimulus(4000);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter on the icestick debug build between several byte-stream requesters: the debug core response path, a status/heartbeat reporter and similar sources. It grants the transmitter to one requester per message, round-robin, and holds the grant until that requester's last byte has been serialized. A timeout releases a stalled owner. It sits between the requesters and the UART transmit serializer that drives the tx pin.

## Interface
Parameters:
- N_REQ, 4: number of requesters, ≥2.
- TIMEOUT, 1024: idle cycles allowed mid-message before the grant is revoked, ≥1.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_data  in  8*N_REQ  packed bytes; requester i occupies [8i+7:8i].
- req_valid  in  N_REQ  requester i has a byte available.
- req_last  in  N_REQ  the byte from requester i is the final byte of its message; qualified by req_valid.
- req_ready  out  N_REQ  byte accepted this cycle when ready & valid.
- tx_data  out  8  byte to the serializer.
- tx_start  out  1  one-cycle pulse; serializer loads tx_data.
- tx_busy  in  1  serializer is shifting a byte.
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- active  out  1  a message is in progress.

## Operation
- The state machine has four states: IDLE, LOAD, SEND and WAIT.
- Arbitration happens in IDLE whenever any req_valid bit is high.
  - Search starts at (ptr+1) mod N_REQ and takes the first requester with valid set.
  - The winner is registered into grant, active goes to 1, and the state moves to LOAD.
- Request lines are sampled only in IDLE. A requester that raises valid while another owns the grant waits its turn.
- In LOAD for owner g:
  - req_ready[g] = !tx_busy, combinational from state and tx_busy. All other req_ready bits are 0.
  - On req_valid[g] & req_ready[g]: latch req_data[g] into tx_data, latch req_last[g] into last_q, clear the timeout counter, and move to SEND.
- SEND lasts exactly one cycle.
  - tx_start = 1 in this cycle only.
  - tx_busy is ignored in SEND.
  - Next state is WAIT.
- WAIT holds while tx_busy = 1. On tx_busy = 0:
  - if last_q = 1: ptr ← g, grant ← 0, active ← 0, go to IDLE.
  - otherwise go to LOAD.
- Timeout:
  - In LOAD, the counter increments each cycle req_valid[g] = 0 and saturates at TIMEOUT.
  - When it reaches TIMEOUT, the message is abandoned: ptr ← g, grant ← 0, active ← 0, go to IDLE. No byte is sent.
  - The counter is cleared on entry to LOAD.
- ptr is ceil(log2(N_REQ)) bits wide. Wrap from N_REQ-1 to 0 is explicit; the design must not rely on power-of-two N_REQ.
- Reset values:
  - state = IDLE, ptr = N_REQ-1, so requester 0 wins first after reset.
  - grant = 0, active = 0, tx_start = 0, tx_data = 8'h00, req_ready = 0, last_q = 0, counter = 0.
- Reset asserted mid-message takes effect at the next clock edge.
  - Everything returns to reset values and any tx_start pulse in flight is dropped.
  - Bytes already handed to the serializer are not recalled.

## Timing
- Idle to first accept: the cycle after valid is seen in IDLE, grant is valid and the state is LOAD. req_ready[g] can be high that cycle if tx_busy = 0.
- Accept at cycle t produces tx_start = 1 with tx_data stable at t+1. WAIT begins at t+2.
- The serializer must raise tx_busy no later than the cycle after tx_start, i.e. at t+2.
- tx_data holds its value until the next accept.
- Minimum spacing between accepts within one message is 3 cycles plus the serializer busy time.
- Release: grant clears in the cycle after WAIT sees tx_busy = 0 with last_q = 1. Re-arbitration takes one further cycle in IDLE.
- Single-byte message (valid and last together on the first byte): IDLE → LOAD → SEND → WAIT → IDLE, with one tx_start.
- At most one req_ready bit is high in any cycle.
- tx_start is never high for two consecutive cycles.

## Test plan
- Reset release, requester 1 sends 3 bytes 0x41 0x42 0x43 (last on 0x43), serializer busy 10 cycles per byte:
  - three tx_start pulses in order, grant = 4'b0010 throughout;
  - grant returns to 0 one cycle after the final busy falls.
- Requesters 0 and 2 both valid at reset release, 2-byte messages each:
  - requester 0 is served completely, then requester 2;
  - no interleaving of bytes on tx_data.
- Fairness: all four requesters hold valid continuously with 1-byte messages. Grant order is 0, 1, 2, 3, 0, 1, … and no requester is served twice before all others are served once.
- Stalled owner: requester 3 sends 1 byte without last, then drops valid. With TIMEOUT = 16:
  - grant clears 16 cycles after LOAD entry;
  - the next pending requester wins;
  - no extra tx_start is issued.
- Backpressure: tx_busy is held high when LOAD is entered. req_ready stays 0 until busy falls; accept then occurs in that same cycle.
- Reset asserted during WAIT of the second byte of a 3-byte message:
  - next cycle grant = 0, active = 0, tx_start = 0, tx_data = 0x00;
  - after reset, requester 0 has priority again.
